lsu_mem_stage: RTL

Load/store unit for the memory stage of the RV64 pipeline. It sits directly downstream of the execute-stage ALU and consumes the ALU result as the effective address. It runs one data-memory transaction at a time over a valid/ready request channel with a separate response strobe. It aligns and extends load data, builds byte masks for stores, and flags misaligned or illegal accesses without touching memory.

---
 rtl/lsu_mem_stage_if.sv | 25 ++
 rtl/lsu_mem_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage_if.sv
// Data-memory request/response bus between the load/store unit and memory.
// The LSU drives the request side; memory answers with a response strobe.
interface lsu_mem_stage_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [7:0]        mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one transaction at a time, load alignment
// and extension, store lane replication and byte masks, fault detection.
module lsu_mem_stage #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic                 ex_re,
    input  logic                 ex_we,
    input  logic [2:0]           ex_funct3,
    input  logic [ADDR_W-1:0]    ex_addr,
    input  logic [DATA_W-1:0]    ex_wdata,
    lsu_mem_stage_if.master      mem,
    output logic                 lsu_busy,
    output logic                 lsu_done,
    output logic [DATA_W-1:0]    lsu_rdata,
    output logic                 lsu_fault
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        offs_q, offs_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        wmask_q, wmask_d;
    logic              req_valid_q, req_valid_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              accept;
    logic              acc_fault;
    logic [DATA_W-1:0] st_data;
    logic [7:0]        st_mask;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] ld_data;

    // Decode the presented op: alignment/legality check and store lane layout.
    always_comb begin
        accept    = ex_valid && (ex_re || ex_we);
        acc_fault = 1'b0;
        st_data   = ex_wdata;
        st_mask   = 8'hFF;
        case (ex_funct3[1:0])
            2'b00: begin
                st_data = {8{ex_wdata[7:0]}};
                st_mask = 8'h01 << ex_addr[2:0];
            end
            2'b01: begin
                acc_fault = ex_addr[0];
                st_data   = {4{ex_wdata[15:0]}};
                st_mask   = 8'h03 << ex_addr[2:0];
            end
            2'b10: begin
                acc_fault = (ex_addr[1:0] != 2'b00);
                st_data   = {2{ex_wdata[31:0]}};
                st_mask   = 8'h0F << ex_addr[2:0];
            end
            default: begin
                acc_fault = (ex_addr[2:0] != 3'b000);
                st_data   = ex_wdata;
                st_mask   = 8'hFF;
            end
        endcase
        if (ex_we && ex_funct3[2]) begin
            acc_fault = 1'b1;
        end
        if (!ex_we && (ex_funct3 == 3'b111)) begin
            acc_fault = 1'b1;
        end
    end

    // Shift the returned doubleword down to the addressed byte and extend it.
    always_comb begin
        lane = mem.mem_rdata >> {offs_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{56{lane[7]}}, lane[7:0]};
            3'b001:  ld_data = {{48{lane[15]}}, lane[15:0]};
            3'b010:  ld_data = {{32{lane[31]}}, lane[31:0]};
            3'b100:  ld_data = {56'd0, lane[7:0]};
            3'b101:  ld_data = {48'd0, lane[15:0]};
            3'b110:  ld_data = {32'd0, lane[31:0]};
            default: ld_data = lane;
        endcase
    end

    // Next-state logic for the IDLE/REQ/WAIT/DONE sequencer and its outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        offs_d      = offs_q;
        funct3_d    = funct3_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        req_valid_d = req_valid_q;
        done_d      = 1'b0;
        fault_d     = fault_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d   = {ex_addr[ADDR_W-1:3], 3'b000};
                    offs_d   = ex_addr[2:0];
                    funct3_d = ex_funct3;
                    wen_d    = ex_we;
                    wdata_d  = st_data;
                    wmask_d  = (ex_we && !acc_fault) ? st_mask : 8'h00;
                    rdata_d  = '0;
                    fault_d  = acc_fault;
                    if (acc_fault) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    state_d     = WAIT;
                    req_valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (mem.mem_resp_valid) begin
                    if (!wen_q) begin
                        rdata_d = ld_data;
                    end
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            offs_q      <= '0;
            funct3_q    <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            req_valid_q <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            offs_q      <= offs_d;
            funct3_q    <= funct3_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            req_valid_q <= req_valid_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_addr      = addr_q;
    assign mem.mem_wen       = wen_q;
    assign mem.mem_wdata     = wdata_q;
    assign mem.mem_wmask     = wmask_q;
    assign lsu_busy          = (state_q != IDLE);
    assign lsu_done          = done_q;
    assign lsu_rdata         = rdata_q;
    assign lsu_fault         = fault_q;
endmodule
